fetch_unit: RTL

Instruction-fetch stage of the 16-bit pipelined CPU, directly upstream of the instruction memory.
- Owns the program counter (PC) and drives the memory address.
- Captures the returned instruction into the IF/ID pipeline register.
- Launches one of ten preloaded programs on a UART-issued start command (start address = program number × 100).
- Handles stall, branch redirect/flush, and end-of-program detection on the unprogrammed word 0xFFFF.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/fetch_unit_if.sv | 27 ++
 rtl/if_id_reg.sv | 35 +++
 rtl/fetch_unit.sv | 102 ++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction constants, program layout and fetch FSM states.
// Also provides the shift-add start-address helper used by the fetch stage.
package cpu_pkg;

    localparam logic [15:0] NOP_INSTR   = 16'h6F0F;
    localparam logic [15:0] EMPTY_INSTR = 16'hFFFF;
    localparam int          PROG_STRIDE = 100;
    localparam logic [3:0]  PROG_MAX    = 4'd10;
    localparam int          PC_W        = 12;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fetch_state_e;

    // sel*100 without a multiplier: 64+32+4
    function automatic logic [PC_W-1:0] prog_base(input logic [3:0] sel);
        logic [PC_W-1:0] s;
        s = {{(PC_W-4){1'b0}}, sel};
        return (s << 6) + (s << 5) + (s << 2);
    endfunction

    function automatic logic sel_ok(input logic [3:0] sel);
        return (sel != 4'd0) && (sel <= PROG_MAX);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: control inputs, instruction memory address/data, and IF/ID outputs.
// master = fetch unit side, slave = surrounding pipeline / memory / testbench.
interface fetch_unit_if;
    logic        start;
    logic [3:0]  prog_sel;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] M_instruction;
    logic [15:0] PCAdd_pc;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic        if_valid;
    logic        busy;
    logic        done;
    logic        sel_err;

    modport master (
        input  start, prog_sel, stall, branch_taken, branch_target, M_instruction,
        output PCAdd_pc, if_instr, if_pc, if_valid, busy, done, sel_err
    );

    modport slave (
        output start, prog_sel, stall, branch_taken, branch_target, M_instruction,
        input  PCAdd_pc, if_instr, if_pc, if_valid, busy, done, sel_err
    );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, pc and valid flag (33 bits).
// Latency: one cycle from load to outputs.
// Backpressure: hold freezes contents; flush injects a NOP bubble and wins over hold and load.
module if_id_reg #(
    parameter logic [15:0] NOP = 16'h6F0F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        hold,
    input  logic        flush,
    input  logic [15:0] nxt_instr,
    input  logic [15:0] nxt_pc,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic        if_valid
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_instr <= NOP;
            if_pc    <= 16'd0;
            if_valid <= 1'b0;
        end else if (flush) begin
            // bubble keeps the old pc so downstream debug still sees a sensible address
            if_instr <= NOP;
            if_valid <= 1'b0;
        end else if (!hold && load) begin
            if_instr <= nxt_instr;
            if_pc    <= nxt_pc;
            if_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, program launch FSM, branch redirect and end-of-program detect.
// Latency: start -> PC valid after 1 edge; PC -> IF/ID after 1 edge; branch inserts one bubble.
// Backpressure: stall freezes PC and IF/ID; branch_taken overrides stall.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int          ADDR_DEPTH  = 4096,
    parameter int          PROG_STRIDE = cpu_pkg::PROG_STRIDE,
    parameter logic [15:0] NOP_INSTR   = cpu_pkg::NOP_INSTR
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);

    fetch_state_e    state_q, state_nxt;
    logic [PC_W-1:0] pc_q, pc_nxt;
    logic [PC_W-1:0] start_addr;
    logic            sel_err_q, sel_err_nxt;
    logic            ifid_load, ifid_hold, ifid_flush;
    logic            unused_target_bits;

    assign unused_target_bits = ^bus.branch_target[15:PC_W];

    if (PROG_STRIDE == 100) begin : g_shift_base
        assign start_addr = prog_base(bus.prog_sel);
    end else begin : g_mul_base
        assign start_addr = PC_W'(32'(bus.prog_sel) * PROG_STRIDE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            pc_q      <= pc_nxt;
            sel_err_q <= sel_err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        pc_nxt      = pc_q;
        sel_err_nxt = 1'b0;
        ifid_load   = 1'b0;
        ifid_hold   = 1'b1;
        ifid_flush  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (sel_ok(bus.prog_sel)) begin
                        state_nxt = RUN;
                        pc_nxt    = start_addr;
                    end else begin
                        sel_err_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.branch_taken) begin
                    pc_nxt     = bus.branch_target[PC_W-1:0];
                    ifid_flush = 1'b1;
                    ifid_hold  = 1'b0;
                end else if (bus.stall) begin
                    pc_nxt = pc_q;
                end else if (bus.M_instruction == EMPTY_INSTR) begin
                    // unprogrammed word marks end of program; never latched
                    state_nxt  = DONE;
                    ifid_flush = 1'b1;
                    ifid_hold  = 1'b0;
                end else begin
                    ifid_load = 1'b1;
                    ifid_hold = 1'b0;
                    pc_nxt    = (pc_q == PC_W'(ADDR_DEPTH - 1)) ? '0 : pc_q + 1'b1;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    if_id_reg #(.NOP(NOP_INSTR)) u_if_id (
        .clk       (clk),
        .reset     (reset),
        .load      (ifid_load),
        .hold      (ifid_hold),
        .flush     (ifid_flush),
        .nxt_instr (bus.M_instruction),
        .nxt_pc    (bus.PCAdd_pc),
        .if_instr  (bus.if_instr),
        .if_pc     (bus.if_pc),
        .if_valid  (bus.if_valid)
    );

    assign bus.PCAdd_pc = 16'(pc_q);
    assign bus.busy     = (state_q == RUN);
    assign bus.done     = (state_q == DONE);
    assign bus.sel_err  = sel_err_q;

endmodule
